// File: rtl/mmu_ws.sv
// Memory map unit between core ports and BRAM / I/O bank; RAM loads return next cycle, I/O waits on io_ready.
// Illegal byte-enable shapes, unmapped addresses and I/O timeouts complete as one-cycle faults.
module mmu_ws #(
    parameter int          WORD_DEPTH_LOG = 16,
    parameter logic [31:0] IO_BASE        = 32'h8000_0000,
    parameter int          IO_ADDR_W      = 8,
    parameter int          IO_TIMEOUT     = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               im_addr,
    output logic [31:0]               im_do,
    output logic [WORD_DEPTH_LOG-3:0] ram_iaddr,
    input  logic [31:0]               ram_irdata,
    input  logic                      dm_req,
    input  logic                      dm_we,
    input  logic [31:0]               dm_addr,
    input  logic [31:0]               dm_di,
    input  logic [3:0]                dm_be,
    input  logic                      is_signed,
    output logic [31:0]               dm_do,
    output logic                      dm_stall,
    output logic                      dm_fault,
    output logic [WORD_DEPTH_LOG-3:0] ram_addr,
    output logic [3:0]                ram_wstrb,
    output logic [31:0]               ram_wdata,
    input  logic [31:0]               ram_rdata,
    output logic [IO_ADDR_W-1:0]      io_addr,
    output logic                      io_en,
    output logic                      io_we,
    output logic [31:0]               io_data_write,
    input  logic [31:0]               io_data_read,
    input  logic                      io_ready
);

    typedef enum logic {IDLE, IO_WAIT} state_t;

    function automatic logic be_ok(input logic [3:0] be);
        case (be)
            4'b1111, 4'b1100, 4'b0011,
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Bit offset of the lowest enabled lane.
    function automatic logic [4:0] lane_shift(input logic [3:0] be);
        case (be)
            4'b0010:          return 5'd8;
            4'b0100, 4'b1100: return 5'd16;
            4'b1000:          return 5'd24;
            default:          return 5'd0;
        endcase
    endfunction

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  io_en_q, io_en_d;
    logic                  io_we_q, io_we_d;
    logic [IO_ADDR_W-1:0]  io_addr_q, io_addr_d;
    logic [31:0]           io_wdata_q, io_wdata_d;
    logic [31:0]           io_rdata_q, io_rdata_d;
    logic [3:0]            req_be_q, req_be_d;
    logic                  req_signed_q, req_signed_d;
    logic [3:0]            be_q, be_d;
    logic                  signed_q, signed_d;
    logic                  dev_io_q, dev_io_d;
    logic                  fault_q, fault_d;

    logic        is_ram, is_io, legal, acc_fault, ram_go, io_go, tmo_hit;
    logic [31:0] wdata_sh;
    logic        unused_im;

    assign unused_im = ^{im_addr[31:WORD_DEPTH_LOG], im_addr[1:0]};

    assign im_do     = ram_irdata;
    assign ram_iaddr = im_addr[WORD_DEPTH_LOG-1:2];

    assign legal     = be_ok(dm_be);
    assign is_ram    = ~dm_addr[31];
    assign is_io     = (dm_addr[31:IO_ADDR_W] == IO_BASE[31:IO_ADDR_W]);
    assign acc_fault = ~legal | (~is_ram & ~is_io);
    assign ram_go    = legal & is_ram;
    assign io_go     = legal & is_io;
    assign tmo_hit   = (cnt_q == 8'(IO_TIMEOUT - 1));
    assign wdata_sh  = dm_di << lane_shift(dm_be);

    assign ram_addr  = dm_addr[WORD_DEPTH_LOG-1:2];
    assign ram_wdata = wdata_sh;
    assign ram_wstrb = (state_q == IDLE && dm_req && ram_go && dm_we) ? dm_be : 4'b0000;

    assign dm_stall = ((state_q == IDLE) && dm_req && io_go) ||
                      ((state_q == IO_WAIT) && !io_ready && !tmo_hit);
    assign dm_fault = fault_q;

    assign io_en         = io_en_q;
    assign io_we         = io_we_q;
    assign io_addr       = io_addr_q;
    assign io_data_write = io_wdata_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        io_en_d      = io_en_q;
        io_we_d      = io_we_q;
        io_addr_d    = io_addr_q;
        io_wdata_d   = io_wdata_q;
        io_rdata_d   = io_rdata_q;
        req_be_d     = req_be_q;
        req_signed_d = req_signed_q;
        be_d         = 4'b0000;
        signed_d     = 1'b0;
        dev_io_d     = 1'b0;
        fault_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm_req) begin
                    if (acc_fault) begin
                        fault_d = 1'b1;
                    end else if (is_ram) begin
                        be_d     = dm_be;
                        signed_d = is_signed;
                    end else begin
                        state_d      = IO_WAIT;
                        cnt_d        = 8'd0;
                        io_en_d      = 1'b1;
                        io_we_d      = dm_we;
                        io_addr_d    = dm_addr[IO_ADDR_W-1:0];
                        io_wdata_d   = wdata_sh;
                        req_be_d     = dm_be;
                        req_signed_d = is_signed;
                    end
                end
            end
            IO_WAIT: begin
                // A ready on the last allowed cycle is a success, not a timeout.
                if (io_ready) begin
                    state_d    = IDLE;
                    io_en_d    = 1'b0;
                    io_rdata_d = io_data_read;
                    be_d       = req_be_q;
                    signed_d   = req_signed_q;
                    dev_io_d   = 1'b1;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    io_en_d = 1'b0;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            io_en_q      <= 1'b0;
            io_we_q      <= 1'b0;
            io_addr_q    <= '0;
            io_wdata_q   <= 32'd0;
            io_rdata_q   <= 32'd0;
            req_be_q     <= 4'b0000;
            req_signed_q <= 1'b0;
            be_q         <= 4'b0000;
            signed_q     <= 1'b0;
            dev_io_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            io_en_q      <= io_en_d;
            io_we_q      <= io_we_d;
            io_addr_q    <= io_addr_d;
            io_wdata_q   <= io_wdata_d;
            io_rdata_q   <= io_rdata_d;
            req_be_q     <= req_be_d;
            req_signed_q <= req_signed_d;
            be_q         <= be_d;
            signed_q     <= signed_d;
            dev_io_q     <= dev_io_d;
            fault_q      <= fault_d;
        end
    end

    logic [31:0] sel_data, aligned;

    always_comb begin
        sel_data = dev_io_q ? io_rdata_q : ram_rdata;
        aligned  = sel_data >> lane_shift(be_q);
        case (be_q)
            4'b1111:          dm_do = aligned;
            4'b1100, 4'b0011: dm_do = {{16{signed_q & aligned[15]}}, aligned[15:0]};
            4'b0001, 4'b0010,
            4'b0100, 4'b1000: dm_do = {{24{signed_q & aligned[7]}}, aligned[7:0]};
            default:          dm_do = 32'd0;
        endcase
        if (fault_q) dm_do = 32'd0;
    end

endmodule
